// File: rtl/hack_ps2_keyboard_pkg.sv
// Scancode and Hack key-code constants, receiver state type and set-2 lookup tables.
// Latency: n/a (package). Backpressure: n/a.
package hack_kbd_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;

    localparam logic [7:0] KEY_NEWLINE = 8'd128, KEY_BACKSPACE = 8'd129;
    localparam logic [7:0] KEY_LEFT = 8'd130, KEY_UP = 8'd131, KEY_RIGHT = 8'd132, KEY_DOWN = 8'd133;
    localparam logic [7:0] KEY_HOME = 8'd134, KEY_END = 8'd135, KEY_PGUP = 8'd136, KEY_PGDN = 8'd137;
    localparam logic [7:0] KEY_INSERT = 8'd138, KEY_DELETE = 8'd139, KEY_ESC = 8'd140;
    localparam logic [7:0] KEY_F1 = 8'd141, KEY_F2 = 8'd142, KEY_F3 = 8'd143, KEY_F4 = 8'd144;
    localparam logic [7:0] KEY_F5 = 8'd145, KEY_F6 = 8'd146, KEY_F7 = 8'd147, KEY_F8 = 8'd148;
    localparam logic [7:0] KEY_F9 = 8'd149, KEY_F10 = 8'd150, KEY_F11 = 8'd151, KEY_F12 = 8'd152;

    localparam logic [7:0] CH_BQUOTE = 8'h60;
    localparam logic [7:0] CH_BSLASH = 8'h5C;
    localparam logic [7:0] CH_DQUOTE = 8'h22;
    localparam logic [7:0] CH_TILDE  = 8'h7E;

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    // key = {extended, scancode}; 0 means unmapped
    function automatic logic [7:0] kbd_base(input logic [8:0] key);
        logic [7:0] c;
        c = 8'd0;
        case (key)
            9'h01C: c = "a";  9'h032: c = "b";  9'h021: c = "c";  9'h023: c = "d";
            9'h024: c = "e";  9'h02B: c = "f";  9'h034: c = "g";  9'h033: c = "h";
            9'h043: c = "i";  9'h03B: c = "j";  9'h042: c = "k";  9'h04B: c = "l";
            9'h03A: c = "m";  9'h031: c = "n";  9'h044: c = "o";  9'h04D: c = "p";
            9'h015: c = "q";  9'h02D: c = "r";  9'h01B: c = "s";  9'h02C: c = "t";
            9'h03C: c = "u";  9'h02A: c = "v";  9'h01D: c = "w";  9'h022: c = "x";
            9'h035: c = "y";  9'h01A: c = "z";
            9'h045: c = "0";  9'h016: c = "1";  9'h01E: c = "2";  9'h026: c = "3";
            9'h025: c = "4";  9'h02E: c = "5";  9'h036: c = "6";  9'h03D: c = "7";
            9'h03E: c = "8";  9'h046: c = "9";
            9'h00E: c = CH_BQUOTE;  9'h04E: c = "-";  9'h055: c = "=";  9'h054: c = "[";
            9'h05B: c = "]";  9'h05D: c = CH_BSLASH; 9'h04C: c = ";";  9'h052: c = "'";
            9'h041: c = ",";  9'h049: c = ".";  9'h04A: c = "/";  9'h029: c = " ";
            9'h05A: c = KEY_NEWLINE; 9'h066: c = KEY_BACKSPACE; 9'h076: c = KEY_ESC;
            9'h16B: c = KEY_LEFT;  9'h175: c = KEY_UP;   9'h174: c = KEY_RIGHT;  9'h172: c = KEY_DOWN;
            9'h16C: c = KEY_HOME;  9'h169: c = KEY_END;  9'h17D: c = KEY_PGUP;   9'h17A: c = KEY_PGDN;
            9'h170: c = KEY_INSERT; 9'h171: c = KEY_DELETE;
            9'h005: c = KEY_F1;  9'h006: c = KEY_F2;  9'h004: c = KEY_F3;  9'h00C: c = KEY_F4;
            9'h003: c = KEY_F5;  9'h00B: c = KEY_F6;  9'h083: c = KEY_F7;  9'h00A: c = KEY_F8;
            9'h001: c = KEY_F9;  9'h009: c = KEY_F10; 9'h078: c = KEY_F11; 9'h007: c = KEY_F12;
            default: c = 8'd0;
        endcase
        return c;
    endfunction

    // US-layout shifted form of an unshifted code; non-printables pass through
    function automatic logic [7:0] kbd_shift(input logic [7:0] ch);
        logic [7:0] s;
        s = ch;
        if (ch >= "a" && ch <= "z") s = ch - 8'd32;
        case (ch)
            "1": s = "!";  "2": s = "@";  "3": s = "#";  "4": s = "$";  "5": s = "%";
            "6": s = "^";  "7": s = "&";  "8": s = "*";  "9": s = "(";  "0": s = ")";
            CH_BQUOTE: s = CH_TILDE;  "-": s = "_";  "=": s = "+";  "[": s = "{";  "]": s = "}";
            CH_BSLASH: s = "|"; ";": s = ":";  "'": s = CH_DQUOTE; ",": s = "<";  ".": s = ">";
            "/": s = "?";
            default: ;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/hack_ps2_keyboard_if.sv
// PS/2 pins plus the keyboard word and error strobe seen by the Hack memory map.
// Latency: n/a (wiring). Backpressure: none, the PS/2 device is never throttled.
interface hack_ps2_keyboard_if;
    logic        ps2_clk;
    logic        ps2_data;
    logic [15:0] out;
    logic        frame_err;

    modport master (output ps2_clk, ps2_data, input out, frame_err);
    modport slave  (input ps2_clk, ps2_data, output out, frame_err);
endinterface

// File: rtl/hack_ps2_keyboard_rx.sv
// PS/2 device-to-host frame receiver: synchronisers, falling-edge sampling, odd parity, inter-edge timeout.
// Latency: byte_valid/frame_err one cycle after the detected stop-bit edge (edges detected 2 cycles after the pin).
// Backpressure: none; a byte is presented for exactly one cycle.
module ps2_rx
    import hack_kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data_byte,
    output logic       byte_valid,
    output logic       frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

    logic [1:0]    clk_sync, dat_sync;
    logic          clk_prev, fall, din, expire;
    rx_state_t     state, state_nxt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          parity_bit;
    logic [TW-1:0] tmo_cnt;
    logic          vld_nxt, err_nxt;

    // lines idle high, so reset the synchronisers high to avoid a fake edge
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
            clk_prev <= clk_sync[1];
        end
    end

    assign fall      = clk_prev & ~clk_sync[1];
    assign din       = dat_sync[1];
    assign expire    = (state != RX_IDLE) && (tmo_cnt == TMO_MAX);
    assign data_byte = shift;

    // expiry wins over a coincident edge
    always_comb begin
        state_nxt = state;
        vld_nxt   = 1'b0;
        err_nxt   = 1'b0;
        if (expire) begin
            state_nxt = RX_IDLE;
            err_nxt   = 1'b1;
        end else if (fall) begin
            case (state)
                RX_IDLE:   if (!din) state_nxt = RX_DATA;
                RX_DATA:   if (bit_cnt == 3'd7) state_nxt = RX_PARITY;
                RX_PARITY: state_nxt = RX_STOP;
                RX_STOP: begin
                    state_nxt = RX_IDLE;
                    if (din && (^{shift, parity_bit})) vld_nxt = 1'b1;
                    else                               err_nxt = 1'b1;
                end
                default:   state_nxt = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= RX_IDLE;
            bit_cnt    <= 3'd0;
            shift      <= 8'd0;
            parity_bit <= 1'b0;
            tmo_cnt    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            byte_valid <= vld_nxt;
            frame_err  <= err_nxt;
            if (state == RX_IDLE || fall || expire) tmo_cnt <= '0;
            else                                    tmo_cnt <= tmo_cnt + 1'b1;
            if (fall && !expire) begin
                if (state == RX_IDLE) bit_cnt <= 3'd0;
                if (state == RX_DATA) begin
                    shift   <= {din, shift[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                end
                if (state == RX_PARITY) parity_bit <= din;
            end
        end
    end

endmodule

// File: rtl/hack_ps2_keyboard.sv
// Hack keyboard word from PS/2 set-2 scancodes (make/break/extended); HACK_KBD_SHIFT_EN adds shift tracking.
// Latency: out updates one cycle after the receiver's byte strobe.
// Backpressure: none; every received byte is consumed in the cycle it is presented.
module hack_ps2_keyboard
    import hack_kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                 clock,
    input  logic                 reset,
    hack_ps2_keyboard_if.slave   kbd
);
    logic [7:0]  data_byte, code;
    logic        byte_valid, rx_err;
    logic        ext, brk, is_shift;
    logic [8:0]  key, held;
    logic [15:0] out_q;

    ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
        .clock      (clock),
        .reset      (reset),
        .ps2_clk    (kbd.ps2_clk),
        .ps2_data   (kbd.ps2_data),
        .data_byte  (data_byte),
        .byte_valid (byte_valid),
        .frame_err  (rx_err)
    );

    assign key           = {ext, data_byte};
    assign kbd.out       = out_q;
    assign kbd.frame_err = rx_err;

`ifdef HACK_KBD_SHIFT_EN
    logic lshift, rshift;

    assign is_shift = !ext && (data_byte == SC_LSHIFT || data_byte == SC_RSHIFT);
    assign code     = (lshift | rshift) ? kbd_shift(kbd_base(key)) : kbd_base(key);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lshift <= 1'b0;
            rshift <= 1'b0;
        end else if (byte_valid && is_shift) begin
            if (data_byte == SC_LSHIFT) lshift <= !brk;
            else                        rshift <= !brk;
        end
    end
`else
    assign is_shift = 1'b0;
    assign code     = kbd_base(key);
`endif

    // held remembers the scancode, so a break matches regardless of shift changes
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ext   <= 1'b0;
            brk   <= 1'b0;
            held  <= '0;
            out_q <= '0;
        end else if (byte_valid) begin
            case (data_byte)
                SC_EXT:   ext <= 1'b1;
                SC_BREAK: brk <= 1'b1;
                default: begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                    if (!is_shift) begin
                        if (brk) begin
                            if (key == held) begin
                                out_q <= '0;
                                held  <= '0;
                            end
                        end else if (code != 8'd0) begin
                            out_q <= {8'd0, code};
                            held  <= key;
                        end
                    end
                end
            endcase
        end
    end

endmodule
